// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the adder_arbiter block.
//   state_t       : FSM state encoding (IDLE, GRANT, EXEC, DONE)
//   DEFAULT_WIDTH : default operand/sum width in bits
package adder_arbiter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        EXEC  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester-side bus of the adder_arbiter.
//   Req0/Req1         : level requests from requester 0/1
//   A0/B0, A1/B1      : operands of requester 0/1
//   Gnt0/Gnt1         : one-cycle grant pulses
//   Sum/Overflow      : result of the last completed addition
//   Valid0/Valid1     : one-cycle result-valid pulses per requester
//   Busy              : arbiter is not idle
// master = requester side (testbench), slave = arbiter side.
interface adder_arbiter_if
    import adder_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             Req0;
    logic             Req1;
    logic [WIDTH-1:0] A0;
    logic [WIDTH-1:0] B0;
    logic [WIDTH-1:0] A1;
    logic [WIDTH-1:0] B1;
    logic             Gnt0;
    logic             Gnt1;
    logic [WIDTH-1:0] Sum;
    logic             Overflow;
    logic             Valid0;
    logic             Valid1;
    logic             Busy;

    modport master (
        output Req0, Req1, A0, B0, A1, B1,
        input  Gnt0, Gnt1, Sum, Overflow, Valid0, Valid1, Busy
    );

    modport slave (
        input  Req0, Req1, A0, B0, A1, B1,
        output Gnt0, Gnt1, Sum, Overflow, Valid0, Valid1, Busy
    );

endinterface

// File: rtl/adder_arbiter_rr_pick.sv
// Combinational two-way round-robin picker.
//   req0/req1 : requests
//   last      : index of the requester served last
//   valid     : at least one request is present
//   idx       : winning requester index
module rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic idx
);

    always_comb begin
        valid = req0 | req1;
        idx   = 1'b0;
        if (req0 && req1) begin
            // Tie: the requester not served last wins.
            idx = ~last;
        end else begin
            idx = req1;
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Two-requester round-robin arbiter in front of a single registered adder.
//   Clk   : sole clock, rising edge
//   Reset : synchronous, active-high
//   bus   : adder_arbiter_if.slave (requests, operands, grants, result)
// Each service takes GRANT -> EXEC -> DONE; requests are only sampled in
// IDLE and DONE, giving one result every three cycles when back-to-back.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input logic          Clk,
    input logic          Reset,
    adder_arbiter_if.slave bus
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_q;
    logic             ovf_q;
    // Last-served pointer; it is also the recorded winner of the
    // operation in flight, since both update on entry to GRANT.
    logic             last;
    logic             pick_valid;
    logic             pick_idx;
    logic             sample;

    rr_pick u_pick (
        .req0  (bus.Req0),
        .req1  (bus.Req1),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_next = state;
        sample     = 1'b0;
        case (state)
            IDLE, DONE: begin
                sample     = 1'b1;
                state_next = pick_valid ? GRANT : IDLE;
            end
            GRANT:   state_next = EXEC;
            EXEC:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            last  <= 1'b1;
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_next;
            if (sample && pick_valid) begin
                op_a <= pick_idx ? bus.A1 : bus.A0;
                op_b <= pick_idx ? bus.B1 : bus.B0;
                last <= pick_idx;
            end
            if (state == EXEC) begin
                {ovf_q, sum_q} <= {1'b0, op_a} + {1'b0, op_b};
            end
        end
    end

    always_comb begin
        bus.Gnt0     = (state == GRANT) && !last;
        bus.Gnt1     = (state == GRANT) &&  last;
        bus.Valid0   = (state == DONE)  && !last;
        bus.Valid1   = (state == DONE)  &&  last;
        bus.Busy     = (state != IDLE);
        bus.Sum      = sum_q;
        bus.Overflow = ovf_q;
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: a table of single-request
// transactions plus directed tie, operand-stability, reset and
// late-request sequences.
module tb_adder_arbiter;

    logic Clk;
    logic Reset;
    int   n_checks;
    int   n_fail;

    adder_arbiter_if #(.WIDTH(4)) bus ();

    adder_arbiter #(.WIDTH(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic who;
        int   a;
        int   b;
        int   sum;
        int   ovf;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    always @(negedge Clk) begin
        if (!Reset) begin
            check("gnt_mutex", int'(bus.Gnt0 & bus.Gnt1), 0);
            check("valid_mutex", int'(bus.Valid0 & bus.Valid1), 0);
        end
    end

    task automatic run_single(input vec_t v, input int i);
        if (v.who) begin
            bus.Req1 = 1'b1; bus.A1 = 4'(v.a); bus.B1 = 4'(v.b);
        end else begin
            bus.Req0 = 1'b1; bus.A0 = 4'(v.a); bus.B0 = 4'(v.b);
        end
        step();                                   // GRANT
        check($sformatf("v%0d_gnt0", i), int'(bus.Gnt0), int'(!v.who));
        check($sformatf("v%0d_gnt1", i), int'(bus.Gnt1), int'(v.who));
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
        step();                                   // EXEC
        check($sformatf("v%0d_busy_exec", i), int'(bus.Busy), 1);
        step();                                   // DONE
        check($sformatf("v%0d_valid0", i), int'(bus.Valid0), int'(!v.who));
        check($sformatf("v%0d_valid1", i), int'(bus.Valid1), int'(v.who));
        check($sformatf("v%0d_sum", i), int'(bus.Sum), v.sum);
        check($sformatf("v%0d_ovf", i), int'(bus.Overflow), v.ovf);
        step();                                   // IDLE
        check($sformatf("v%0d_busy_idle", i), int'(bus.Busy), 0);
        check($sformatf("v%0d_sum_hold", i), int'(bus.Sum), v.sum);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{1'b0, 3, 4, 7, 0};
        vecs[1] = '{1'b1, 9, 8, 1, 1};
        vecs[2] = '{1'b0, 15, 15, 14, 1};
        vecs[3] = '{1'b1, 0, 0, 0, 0};
        vecs[4] = '{1'b0, 8, 7, 15, 0};
        vecs[5] = '{1'b1, 15, 1, 0, 1};

        bus.Req0 = 1'b0; bus.Req1 = 1'b0;
        bus.A0 = '0; bus.B0 = '0; bus.A1 = '0; bus.B1 = '0;
        Reset = 1'b1;
        step();
        step();
        check("rst_gnt0", int'(bus.Gnt0), 0);
        check("rst_gnt1", int'(bus.Gnt1), 0);
        check("rst_valid0", int'(bus.Valid0), 0);
        check("rst_valid1", int'(bus.Valid1), 0);
        check("rst_busy", int'(bus.Busy), 0);
        check("rst_sum", int'(bus.Sum), 0);
        check("rst_ovf", int'(bus.Overflow), 0);
        Reset = 1'b0;
        step();

        for (int i = 0; i < 6; i++) run_single(vecs[i], i);

        // Tie after reset: 0, 1, 0 with both requests held.
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        bus.Req0 = 1'b1; bus.A0 = 4'd1; bus.B0 = 4'd2;
        bus.Req1 = 1'b1; bus.A1 = 4'd5; bus.B1 = 4'd6;
        for (int s = 0; s < 3; s++) begin
            step();                               // GRANT
            check($sformatf("tie%0d_gnt0", s), int'(bus.Gnt0), int'(s != 1));
            check($sformatf("tie%0d_gnt1", s), int'(bus.Gnt1), int'(s == 1));
            if (s == 2) begin
                bus.Req0 = 1'b0;
                bus.Req1 = 1'b0;
            end
            step();                               // EXEC
            check($sformatf("tie%0d_noval", s), int'(bus.Valid0 | bus.Valid1), 0);
            step();                               // DONE
            check($sformatf("tie%0d_valid0", s), int'(bus.Valid0), int'(s != 1));
            check($sformatf("tie%0d_valid1", s), int'(bus.Valid1), int'(s == 1));
            check($sformatf("tie%0d_sum", s), int'(bus.Sum), (s == 1) ? 11 : 3);
        end
        step();
        check("tie_busy_idle", int'(bus.Busy), 0);

        // Operand change after grant must not affect the result.
        bus.Req0 = 1'b1; bus.A0 = 4'd2; bus.B0 = 4'd2;
        step();
        check("stab_gnt0", int'(bus.Gnt0), 1);
        bus.Req0 = 1'b0;
        step();
        bus.A0 = 4'd15;
        step();
        check("stab_valid0", int'(bus.Valid0), 1);
        check("stab_sum", int'(bus.Sum), 4);
        check("stab_ovf", int'(bus.Overflow), 0);
        step();

        // Reset in EXEC aborts the operation; pointer returns to 1.
        bus.Req1 = 1'b1; bus.A1 = 4'd3; bus.B1 = 4'd3;
        step();
        check("rmid_gnt1", int'(bus.Gnt1), 1);
        bus.Req1 = 1'b0;
        step();
        check("rmid_exec_busy", int'(bus.Busy), 1);
        Reset = 1'b1;
        step();
        check("rmid_valid", int'(bus.Valid0 | bus.Valid1), 0);
        check("rmid_busy", int'(bus.Busy), 0);
        check("rmid_sum", int'(bus.Sum), 0);
        check("rmid_ovf", int'(bus.Overflow), 0);
        check("rmid_gnt", int'(bus.Gnt0 | bus.Gnt1), 0);
        Reset = 1'b0;
        bus.Req0 = 1'b1; bus.A0 = 4'd4; bus.B0 = 4'd5;
        bus.Req1 = 1'b1; bus.A1 = 4'd1; bus.B1 = 4'd1;
        step();
        check("rmid_tie_gnt0", int'(bus.Gnt0), 1);
        check("rmid_tie_gnt1", int'(bus.Gnt1), 0);
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
        step();
        step();
        check("rmid_tie_valid0", int'(bus.Valid0), 1);
        check("rmid_tie_sum", int'(bus.Sum), 9);
        step();

        // Late request raised during EXEC of a requester-0 operation.
        bus.Req0 = 1'b1; bus.A0 = 4'd6; bus.B0 = 4'd1;
        step();
        check("late_gnt0", int'(bus.Gnt0), 1);
        bus.Req0 = 1'b0;
        step();
        bus.Req1 = 1'b1; bus.A1 = 4'd2; bus.B1 = 4'd3;
        step();
        check("late_valid0", int'(bus.Valid0), 1);
        check("late_sum0", int'(bus.Sum), 7);
        step();
        check("late_gnt1", int'(bus.Gnt1), 1);
        bus.Req1 = 1'b0;
        step();
        step();
        check("late_valid1", int'(bus.Valid1), 1);
        check("late_sum1", int'(bus.Sum), 5);
        step();
        check("late_busy_idle", int'(bus.Busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/sum width in bits.
REQ-002 SHALL have port Clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have ports Req0/Req1, input, 1 each, level request from requester 0/1.
REQ-005 SHALL have ports A0/B0 and A1/B1, input, WIDTH each, operands of requester 0/1, held stable while the matching Req is high.
REQ-006 SHALL have ports Gnt0/Gnt1, output, 1 each, one-cycle grant pulse; operands are captured at the edge that raises it.
REQ-007 SHALL have port Sum, output, WIDTH, result of the last completed addition.
REQ-008 SHALL have port Overflow, output, 1, unsigned carry-out of the last completed addition.
REQ-009 SHALL have ports Valid0/Valid1, output, 1 each, one-cycle pulse marking Sum/Overflow as the result for requester 0/1.
REQ-010 SHALL have port Busy, output, 1, high whenever state is not IDLE.

Function
REQ-011 SHALL implement the FSM IDLE -> GRANT -> EXEC -> DONE.
- IDLE and DONE are the only states that sample requests.
- From either state: to GRANT if any Req is high, else to IDLE.
REQ-012 On entering GRANT, SHALL:
- latch the winner's A/B into internal operand registers;
- record the winner's index;
- drive that requester's Gnt high for exactly the GRANT cycle.
REQ-013 GRANT SHALL always go to EXEC; EXEC SHALL always go to DONE.
REQ-014 At the EXEC->DONE edge, SHALL register {Overflow, Sum} = zero-extended operand A + operand B, a (WIDTH+1)-bit result.
REQ-015 Valid of the recorded winner SHALL be high for exactly the DONE cycle.
REQ-016 Sum/Overflow SHALL hold their value until the next EXEC->DONE edge.
REQ-017 Latency SHALL be:
- Gnt high 1 cycle after the sampling edge;
- Valid high 3 cycles after the sampling edge;
- back-to-back service throughput of one result every 3 cycles.
REQ-018 Arbitration SHALL be round-robin with a last-served pointer.
- Single request: that requester wins.
- Both requesting: the requester not last served wins.
- The pointer updates only on entry to GRANT.
REQ-019 Requests in GRANT and EXEC SHALL be ignored without being lost; a request still high is considered at the next DONE/IDLE sample.
REQ-020 A requester SHALL drop Req after seeing its Gnt. If its Req is still high in DONE, that is a new request.
REQ-021 Gnt0 and Gnt1 SHALL never be high together; the same applies to Valid0 and Valid1.
REQ-022 Operand changes after the grant edge SHALL NOT affect the result.

Reset
REQ-023 Reset high at a rising edge SHALL force:
- state to IDLE;
- Gnt0/Gnt1, Valid0/Valid1, Busy, Sum and Overflow to 0;
- operand registers to 0;
- the last-served pointer to 1, so requester 0 wins the first tie.
REQ-024 Reset during GRANT, EXEC or DONE SHALL abort the operation with no Valid pulse; Reset takes priority over every transition.

Structure
REQ-025 State encoding (IDLE, GRANT, EXEC, DONE) SHALL be defined as constants in a shared package/header, together with the default WIDTH.
REQ-026 SHALL contain one sub-module, rr_pick.
- Purely combinational.
- Inputs: two requests and the last-served pointer.
- Outputs: a valid flag and the winner index.
REQ-027 FSM, operand registers, pointer and result registers SHALL live in adder_arbiter; no other sub-modules.

Verification
REQ-028 Single request:
- Stimulus: Req0=1, A0=3, B0=4 at edge k.
- Required: Gnt0 high in cycle k+1; Valid0 high in cycle k+3 with Sum=7, Overflow=0; Busy low in cycle k+4.
REQ-029 Overflow:
- Stimulus: Req1 with A1=9, B1=8.
- Required: Valid1 with Sum=1, Overflow=1.
REQ-030 Tie after reset:
- Stimulus: Req0 and Req1 both held high.
- Required: grants Gnt0, Gnt1, Gnt0 alternate; Valid pulses 3 cycles apart; each Sum matches the respective operands.
REQ-031 Operand stability:
- Stimulus: Req0 with A0=2, B0=2; change A0 to 15 the cycle after Gnt0.
- Required: Sum=4.
REQ-032 Reset mid-operation:
- Stimulus: assert Reset in EXEC.
- Required: no Valid pulse; all outputs 0 the next cycle; the next tie is won by requester 0.
REQ-033 Late request:
- Stimulus: Req1 raised during EXEC of a requester-0 operation.
- Required: Gnt1 the cycle after DONE; no requester idles more than one service slot when both requests are held.
